// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and default widths for the two-entry skid-buffered pipeline stage.
package pipe_stage_reg_pkg;

  localparam int unsigned DefDataW = 64;
  localparam int unsigned DefCtrlW = 8;
  localparam int unsigned DefCntW  = 16;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One storage slot: valid + ctrl are reset/clearable, data is never cleared.
module pipe_entry #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Clear wins over load so a flush discards a beat arriving the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
    end
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Registered pipeline stage with a skid entry so in_ready is a flop, plus bubble/stall counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned CTRL_W = DefCtrlW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e state_q, state_d;
  logic   in_ready_q;
  logic   in_xfer;

  logic              main_load, main_clr, main_sel_skid, main_valid;
  logic              skid_load, skid_clr, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [CNT_W-1:0]  bubble_q, stall_q;

  assign in_xfer = in_valid & in_ready_q;

  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_clr      = flush;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = flush;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          main_load = 1'b1;
          state_d   = StOne;
        end
      end
      StOne: begin
        if (in_xfer && out_ready) begin
          main_load = 1'b1;
        end else if (in_xfer) begin
          skid_load = 1'b1;
          state_d   = StFull;
        end else if (out_ready) begin
          main_clr = 1'b1;
          state_d  = StEmpty;
        end
      end
      StFull: begin
        if (out_ready && skid_valid) begin
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
          skid_clr      = 1'b1;
          state_d       = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d = StEmpty;
    end
  end

  assign main_data_in = main_sel_skid ? skid_data : in_data;
  assign main_ctrl_in = main_sel_skid ? skid_ctrl : in_ctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StFull);
    end
  end

  pipe_entry #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .load_i (main_load),
    .clr_i  (main_clr),
    .data_i (main_data_in),
    .ctrl_i (main_ctrl_in),
    .valid_o(main_valid),
    .data_o (main_data),
    .ctrl_o (main_ctrl)
  );

  pipe_entry #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (skid_load),
    .clr_i  (skid_clr),
    .data_i (in_data),
    .ctrl_i (in_ctrl),
    .valid_o(skid_valid),
    .data_o (skid_data),
    .ctrl_o (skid_ctrl)
  );

  // Saturating counters; clear has priority, flush does not touch them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_q <= '0;
      stall_q  <= '0;
    end else if (cnt_clr) begin
      bubble_q <= '0;
      stall_q  <= '0;
    end else begin
      if (out_ready && !main_valid && (bubble_q != '1)) begin
        bubble_q <= bubble_q + CNT_W'(1);
      end
      if (main_valid && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid;
  assign out_data   = main_data;
  assign out_ctrl   = main_valid ? main_ctrl : '0;
  assign bubble_cnt = bubble_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: the driver pushes accepted beats, a monitor pops them as they leave.
module tb_pipe_stage_reg;

  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 8;
  localparam int unsigned NW   = 4;
  localparam int unsigned CMAX = 15;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  logic          clk, rst;
  logic          in_valid, in_ready, out_valid, out_ready, flush, cnt_clr;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [NW-1:0] bubble_cnt, stall_cnt;

  beat_t q[$];
  beat_t mon_b;
  int    n_chk  = 0;
  int    n_pass = 0;
  int    bub_m  = 0;
  int    stl_m  = 0;
  bit    rdy_ok = 0;
  bit    acc;

  pipe_stage_reg #(
    .DATA_W(DW),
    .CTRL_W(CW),
    .CNT_W (NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .bubble_cnt(bubble_cnt),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // One clock cycle: check state left by earlier edges, drive inputs, advance the model.
  task automatic cycle(input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit ordy, input bit fl, input bit clr, output bit accepted);
    bit exp_rdy;
    bit ov;
    beat_t b;
    @(negedge clk);
    #1;
    exp_rdy = rdy_ok && (q.size() != 2);
    ov      = (q.size() != 0);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(ov));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(bub_m));
    chk("stall_cnt", 32'(stall_cnt), 32'(stl_m));
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
    accepted  = iv && exp_rdy;
    if (clr) begin
      bub_m = 0;
      stl_m = 0;
    end else begin
      if (ordy && !ov && bub_m < CMAX) bub_m++;
      if (ov && !ordy && stl_m < CMAX) stl_m++;
    end
    if (accepted && !fl) begin
      b.d = d;
      b.c = c;
      q.push_back(b);
    end
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  // Departures: pop on out-transfer, then a flush discards whatever remains.
  always begin
    @(negedge clk);
    #2;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_beat: got data 0x%0h expected no beat at %0t", out_data, $time);
      end else begin
        mon_b = q.pop_front();
        chk("out_data", 32'(out_data), 32'(mon_b.d));
        chk("out_ctrl", 32'(out_ctrl), 32'(mon_b.c));
      end
    end
    if (out_valid !== 1'b1) chk("out_ctrl_idle", 32'(out_ctrl), 32'd0);
    if (flush === 1'b1) q.delete();
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_bubble", 32'(bubble_cnt), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    #2 rst = 1'b1;
    @(posedge clk);
    rdy_ok = 1'b1;

    // Stream 1..8 with out_ready held high.
    for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), CW'(i + 16), 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
    chk("stream_bubble", 32'(bubble_cnt), 32'd1);

    // Backpressure: A, B fill the stage, C waits upstream.
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'h000A, 8'h1A, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'h000B, 8'h1B, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'h000C, 8'h1C, 1'b0, 1'b0, 1'b0, acc);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    chk("bp_c_held", 32'(acc), 32'd0);
    acc = 1'b0;
    for (int i = 0; i < 5 && !acc; i++) cycle(1'b1, 16'h000C, 8'h1C, 1'b1, 1'b0, 1'b0, acc);
    chk("bp_c_accepted", 32'(acc), 32'd1);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    chk("bp_stall", 32'(stall_cnt), 32'd2);

    // Flush while FULL with a beat offered.
    cycle(1'b1, 16'h00D0, 8'h2D, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'h00E0, 8'h2E, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'h00F0, 8'h2F, 1'b0, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_ctrl", 32'(out_ctrl), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);

    // Saturation, then clear colliding with an increment.
    cycle(1'b1, 16'h0123, 8'h33, 1'b0, 1'b0, 1'b0, acc);
    repeat (20) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    chk("stall_sat", 32'(stall_cnt), 32'(CMAX));
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    chk("stall_clr", 32'(stall_cnt), 32'd0);

    // Asynchronous reset between edges while FULL.
    cycle(1'b1, 16'h0AA1, 8'h41, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'h0AA2, 8'h42, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    idle_inputs();
    #3 rst = 1'b0;
    q.delete();
    bub_m  = 0;
    stl_m  = 0;
    rdy_ok = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_ctrl", 32'(out_ctrl), 32'd0);
    chk("arst_stall", 32'(stall_cnt), 32'd0);
    chk("arst_bubble", 32'(bubble_cnt), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    rdy_ok = 1'b1;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(99) < 70), DW'($urandom), CW'($urandom), ($urandom_range(99) < 60),
            ($urandom_range(99) < 5), ($urandom_range(99) < 5), acc);
    end
    repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    chk("drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64: payload width in bits, carried through and never cleared.
REQ-002 Parameter CTRL_W, default 8: control-field width in bits, zeroed on flush and reset.
REQ-003 Parameter CNT_W, default 16: width of each performance counter.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream has a beat.
REQ-007 in_ready  output  1  stage can accept; a beat transfers when in_valid and in_ready are both 1.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 in_ctrl  input  CTRL_W  upstream control bits (regWrite, memWrite and similar).
REQ-010 out_valid  output  1  stage holds a beat for downstream.
REQ-011 out_ready  input  1  downstream accepts; a beat transfers when out_valid and out_ready are both 1.
REQ-012 out_data  output  DATA_W  payload of the head beat.
REQ-013 out_ctrl  output  CTRL_W  control bits of the head beat; forced to 0 whenever out_valid=0.
REQ-014 flush  input  1  kill every beat held in the stage (branch mispredict or exception).
REQ-015 cnt_clr  input  1  synchronous clear of both counters.
REQ-016 bubble_cnt  output  CNT_W  count of cycles with out_ready=1 and out_valid=0.
REQ-017 stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-018 Storage SHALL be two entries, main (head) and skid, each holding a valid bit, data and ctrl.
REQ-019 The FSM SHALL have three states: EMPTY (no entries), ONE (main only) and FULL (main plus skid).
REQ-020 in_ready SHALL equal (state != FULL), be driven directly from a flop, and have no combinational path from out_ready.
REQ-021 Latency SHALL be one cycle: a beat accepted at edge N appears on out_* after edge N when the stage was EMPTY, or ONE with out_ready=1.
REQ-022 EMPTY: accept goes to ONE; otherwise the stage stays EMPTY.
REQ-023 ONE, accept with out_ready=1: main is replaced by the new beat and the stage stays ONE.
REQ-024 ONE, accept with out_ready=0: the new beat goes to skid and the stage goes to FULL.
REQ-025 ONE, no accept with out_ready=1: the stage goes to EMPTY.
REQ-026 FULL, out_ready=1: skid moves to main and the stage goes to ONE; there is no accept because in_ready=0.
REQ-027 FULL, out_ready=0: the stage holds all contents.
REQ-028 Beats SHALL leave in strict acceptance order; none SHALL be duplicated or dropped except by flush.
REQ-029 flush=1 at an edge SHALL clear both valid bits and both ctrl registers and force the state to EMPTY.
REQ-030 When flush and an in-transfer coincide, flush SHALL win: the beat is discarded, although in_ready may read 1 that cycle.
REQ-031 When flush and an out-transfer coincide, the out-transfer completes and flush clears the remainder.
REQ-032 Data registers SHALL NOT be cleared by flush.
REQ-033 Each counter SHALL increment by 1 per qualifying cycle and saturate at 2^CNT_W-1 without wrapping.
REQ-034 cnt_clr SHALL force both counters to 0 at the edge and take priority over increment.
REQ-035 flush SHALL NOT affect the counters.

Reset
REQ-036 rst=0 SHALL immediately, without waiting for clk, force state=EMPTY, both valid bits 0, both ctrl registers 0, both counters 0, out_valid=0 and out_ctrl=0.
REQ-037 in_ready SHALL read 0 while rst=0 and rise on the first edge after release.
REQ-038 Data registers are don't-care out of reset.
REQ-039 Reset asserted mid-transfer SHALL discard all held beats with no partial output.

Structure
REQ-040 A shared package SHALL hold the state enum (EMPTY, ONE, FULL) and the default widths.
REQ-041 One sub-module, pipe_entry, SHALL implement a single entry (valid + data + ctrl, load enable, ctrl-clear) and be instantiated twice.
REQ-042 Counters SHALL be inline.

Verification
REQ-043 Stream: in_valid=1 with data 1..8 and out_ready=1 throughout -> out_data 1..8 on consecutive cycles, each one cycle after acceptance; bubble_cnt=1 for the first cycle.
REQ-044 Backpressure: send 0xA, 0xB and 0xC with out_ready=0 -> stage FULL after 0xB, in_ready=0, 0xC held upstream; then raise out_ready -> order A, B, C and stall_cnt counts every out_ready=0 cycle with out_valid=1.
REQ-045 Flush with FULL and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, state EMPTY and the incoming beat never appears.
REQ-046 Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15; cnt_clr and increment in the same cycle -> 0.
REQ-047 Reset: assert rst=0 between edges while FULL -> out_valid=0 and counters=0 before the next edge; in_ready=1 on the first edge after release.
